// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    STALL
  } meas_state_t;

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous input and flags every transition of the synchronized level.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic inClk,
  input  logic reset,
  input  logic sig_i,
  output logic edge_o,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   prevQ;

  // prev clears to 0 so a high input seen right after reset yields an edge
  always_ff @(posedge inClk) begin
    if (reset) begin
      syncQ <= '0;
      prevQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], sig_i};
      prevQ <= syncQ[SYNC_STAGES-1];
    end
  end

  assign level_o = syncQ[SYNC_STAGES-1];
  assign edge_o  = syncQ[SYNC_STAGES-1] ^ prevQ;

endmodule

// File: rtl/clk_period_meter.sv
// Measures high time, low time and period of an external square wave in inClk cycles,
// flagging lock on repeated equal periods and stall when edges stop arriving.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50_000_000
) (
  input  logic             inClk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] low_count,
  output logic [CNT_W:0]   period_count,
  output logic             valid,
  output logic             locked,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  logic sigEdge;
  logic sigLevel;

  meas_state_t      stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [CNT_W-1:0] highQ, highD;
  logic [CNT_W-1:0] lowQ, lowD;
  logic [CNT_W:0]   periodQ, periodD;
  logic             validQ, validD;
  logic             lockedQ, lockedD;
  logic             stalledQ, stalledD;
  logic             haveHiQ, haveHiD;
  logic             haveLoQ, haveLoD;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uSync (
    .inClk  (inClk),
    .reset  (reset),
    .sig_i  (sig_in),
    .edge_o (sigEdge),
    .level_o(sigLevel)
  );

  // cnt equals the length of the interval just ended whenever an edge is present
  always_comb begin
    cntD = cntQ;
    if (sigEdge) begin
      cntD = CNT_W'(1);
    end else if (cntQ < TimeoutCnt) begin
      cntD = cntQ + 1'b1;
    end
  end

  always_comb begin
    stateD   = stateQ;
    highD    = highQ;
    lowD     = lowQ;
    periodD  = periodQ;
    validD   = 1'b0;
    lockedD  = lockedQ;
    stalledD = 1'b0;
    haveHiD  = haveHiQ;
    haveLoD  = haveLoQ;

    if (!enable) begin
      stateD  = IDLE;
      lockedD = 1'b0;
      haveHiD = 1'b0;
      haveLoD = 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          lockedD = 1'b0;
          haveHiD = 1'b0;
          haveLoD = 1'b0;
          stateD  = ARM;
        end
        ARM: begin
          lockedD = 1'b0;
          if (sigEdge) begin
            stateD = MEASURE;
          end
        end
        MEASURE: begin
          // A rising edge closes a low phase, a falling edge closes a high phase
          if (sigEdge) begin
            if (sigLevel) begin
              lowD    = cntQ;
              haveLoD = 1'b1;
            end else begin
              highD   = cntQ;
              haveHiD = 1'b1;
            end
            if (haveHiD && haveLoD) begin
              validD  = 1'b1;
              periodD = {1'b0, highD} + {1'b0, lowD};
              lockedD = (periodD == periodQ);
            end
          end else if (cntQ >= TimeoutCnt) begin
            stateD   = STALL;
            stalledD = 1'b1;
            lockedD  = 1'b0;
            haveHiD  = 1'b0;
            haveLoD  = 1'b0;
          end
        end
        STALL: begin
          lockedD = 1'b0;
          if (sigEdge) begin
            stateD = MEASURE;
          end else begin
            stalledD = 1'b1;
          end
        end
        default: begin
          stateD = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge inClk) begin
    if (reset) begin
      stateQ   <= IDLE;
      cntQ     <= '0;
      highQ    <= '0;
      lowQ     <= '0;
      periodQ  <= '0;
      validQ   <= 1'b0;
      lockedQ  <= 1'b0;
      stalledQ <= 1'b0;
      haveHiQ  <= 1'b0;
      haveLoQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      highQ    <= highD;
      lowQ     <= lowD;
      periodQ  <= periodD;
      validQ   <= validD;
      lockedQ  <= lockedD;
      stalledQ <= stalledD;
      haveHiQ  <= haveHiD;
      haveLoQ  <= haveLoD;
    end
  end

  assign high_count   = highQ;
  assign low_count    = lowQ;
  assign period_count = periodQ;
  assign valid        = validQ;
  assign locked       = lockedQ;
  assign stalled      = stalledQ;

endmodule
